// File: rtl/background_pipeline.sv
// rtl/background_pipeline.sv - background tile fetch sequencer and pixel shifters
module background_pipeline #(
  parameter logic [3:0] RESET_PIXEL = 4'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clock_EN,
  input  logic        background_EN,
  input  logic        bgLeft_EN,
  input  logic        bgPatternTable,
  input  logic [2:0]  fineX,
  input  logic [14:0] v,
  input  logic        backgroundFetch_EN,
  input  logic        pixelShifty_EN,
  input  logic        dummyFetch_EN,
  input  logic [7:0]  ppuData,
  output logic [13:0] ppuAddr,
  output logic        ppuRead,
  output logic [3:0]  bgPixel
);

  logic [2:0]  ph, ph_next;
  logic [7:0]  nt, pt_lo;
  logic [1:0]  at, at_bits;
  logic [2:0]  at_s;
  logic [15:0] sh_pat_lo, sh_pat_hi, sh_at_lo, sh_at_hi;
  logic [15:0] pat_lo_next, pat_hi_next, at_lo_next, at_hi_next;
  logic        prefetch_group;
  logic [3:0]  px;
  logic [3:0]  pix_idx;
  logic        fetch_real, shift_en, reload;
  logic [13:0] nt_addr, at_addr, pt_lo_addr, pt_hi_addr;

  assign ppuRead    = backgroundFetch_EN;
  assign fetch_real = backgroundFetch_EN && !dummyFetch_EN;
  assign reload     = fetch_real && (ph == 3'd7);
  assign shift_en   = pixelShifty_EN || (fetch_real && prefetch_group);
  assign at_s       = {v[6], v[1], 1'b0};
  assign at_bits    = ppuData[at_s +: 2];
  assign pix_idx    = {1'b1, ~fineX};

  assign nt_addr    = {2'b10, v[11:0]};
  assign at_addr    = {2'b10, v[11:10], 4'b1111, v[9:7], v[4:2]};
  assign pt_lo_addr = {1'b0, bgPatternTable, nt, 1'b0, v[14:12]};
  assign pt_hi_addr = {1'b0, bgPatternTable, nt, 1'b1, v[14:12]};

  always_comb begin
    ppuAddr = nt_addr;
    if (!dummyFetch_EN) begin
      case (ph[2:1])
        2'd0:    ppuAddr = nt_addr;
        2'd1:    ppuAddr = at_addr;
        2'd2:    ppuAddr = pt_lo_addr;
        default: ppuAddr = pt_hi_addr;
      endcase
    end
  end

  always_comb begin
    ph_next = 3'd0;
    if (backgroundFetch_EN) ph_next = ph + 3'd1;
  end

  // The high pattern byte arrives on the reload edge itself, so it goes straight into its shifter.
  always_comb begin
    pat_lo_next = shift_en ? {sh_pat_lo[14:0], 1'b0} : sh_pat_lo;
    pat_hi_next = shift_en ? {sh_pat_hi[14:0], 1'b0} : sh_pat_hi;
    at_lo_next  = shift_en ? {sh_at_lo[14:0], 1'b0}  : sh_at_lo;
    at_hi_next  = shift_en ? {sh_at_hi[14:0], 1'b0}  : sh_at_hi;
    if (reload) begin
      pat_lo_next = {pat_lo_next[15:8], pt_lo};
      pat_hi_next = {pat_hi_next[15:8], ppuData};
      at_lo_next  = {at_lo_next[15:8], {8{at[0]}}};
      at_hi_next  = {at_hi_next[15:8], {8{at[1]}}};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ph             <= 3'd0;
      nt             <= 8'd0;
      at             <= 2'd0;
      pt_lo          <= 8'd0;
      sh_pat_lo      <= 16'd0;
      sh_pat_hi      <= 16'd0;
      sh_at_lo       <= 16'd0;
      sh_at_hi       <= 16'd0;
      prefetch_group <= 1'b0;
      px             <= 4'd0;
      bgPixel        <= RESET_PIXEL;
    end else if (clock_EN) begin
      ph <= ph_next;
      if (backgroundFetch_EN && ph == 3'd1) nt    <= ppuData;
      if (fetch_real && ph == 3'd3)         at    <= at_bits;
      if (fetch_real && ph == 3'd5)         pt_lo <= ppuData;
      sh_pat_lo <= pat_lo_next;
      sh_pat_hi <= pat_hi_next;
      sh_at_lo  <= at_lo_next;
      sh_at_hi  <= at_hi_next;
      if (pixelShifty_EN)  prefetch_group <= 1'b0;
      else if (reload)     prefetch_group <= ~prefetch_group;
      if (!pixelShifty_EN) px <= 4'd0;
      else if (px != 4'd8) px <= px + 4'd1;
      if (pixelShifty_EN) begin
        if (!background_EN || (!bgLeft_EN && px < 4'd8))
          bgPixel <= RESET_PIXEL;
        else
          bgPixel <= {sh_at_hi[pix_idx], sh_at_lo[pix_idx], sh_pat_hi[pix_idx], sh_pat_lo[pix_idx]};
      end
    end
  end

endmodule

// File: tb/tb_background_pipeline.sv
// tb/tb_background_pipeline.sv - directed self-checking bench for background_pipeline
module tb_background_pipeline;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clock_EN = 1'b1;
  logic        background_EN = 1'b1;
  logic        bgLeft_EN = 1'b1;
  logic        bgPatternTable = 1'b0;
  logic [2:0]  fineX = 3'd0;
  logic [14:0] v = 15'h0421;
  logic        backgroundFetch_EN = 1'b1;
  logic        pixelShifty_EN = 1'b0;
  logic        dummyFetch_EN = 1'b0;
  logic [7:0]  ppuData;
  logic [13:0] ppuAddr;
  logic        ppuRead;
  logic [3:0]  bgPixel;

  logic [7:0] tile_nt = 8'h5A, tile_at = 8'h00, tile_lo = 8'h00, tile_hi = 8'h00;
  int checks = 0;
  int failures = 0;

  background_pipeline dut (
    .clock(clock), .reset_n(reset_n), .clock_EN(clock_EN),
    .background_EN(background_EN), .bgLeft_EN(bgLeft_EN),
    .bgPatternTable(bgPatternTable), .fineX(fineX), .v(v),
    .backgroundFetch_EN(backgroundFetch_EN), .pixelShifty_EN(pixelShifty_EN),
    .dummyFetch_EN(dummyFetch_EN), .ppuData(ppuData), .ppuAddr(ppuAddr),
    .ppuRead(ppuRead), .bgPixel(bgPixel)
  );

  always #5 clock = ~clock;

  // Tiny VRAM: attribute region, nametable, pattern low/high planes.
  assign ppuData = ppuAddr[13] ? ((ppuAddr[9:6] == 4'hF) ? tile_at : tile_nt)
                               : (ppuAddr[3] ? tile_hi : tile_lo);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clock_EN = 1'b1;
    pixelShifty_EN = 1'b0;
    dummyFetch_EN = 1'b0;
    backgroundFetch_EN = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic fetch_tile(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] atb);
    tile_lo = lo;
    tile_hi = hi;
    tile_at = atb;
    backgroundFetch_EN = 1'b1;
    pixelShifty_EN = 1'b0;
    repeat (8) tick();
  endtask

  task automatic prefetch_ab();
    do_reset();
    fetch_tile(8'h80, 8'h00, 8'h03);
    fetch_tile(8'h00, 8'hFF, 8'h00);
  endtask

  // exp holds nine pixels, first pixel in the top nibble.
  task automatic run_line(input string tag, input logic [2:0] fx, input logic bg,
                          input logic left, input logic [35:0] exp);
    fineX = fx;
    background_EN = bg;
    bgLeft_EN = left;
    backgroundFetch_EN = 1'b0;
    pixelShifty_EN = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("%s_px%0d", tag, i + 1), {28'd0, bgPixel}, {28'd0, exp[35 - 4*i -: 4]});
    end
    pixelShifty_EN = 1'b0;
    fineX = 3'd0;
    background_EN = 1'b1;
    bgLeft_EN = 1'b1;
  endtask

  logic [13:0] addr_exp [4];

  initial begin
    addr_exp = '{14'h2421, 14'h27C0, 14'h15A0, 14'h15A8};
    #1;

    // Reset held two cycles with the fetch strobe up
    tick();
    tick();
    check("rst_pixel", {28'd0, bgPixel}, 32'h0);
    check("rst_ph", {29'd0, dut.ph}, 32'h0);
    check("rst_addr", {18'd0, ppuAddr}, 32'h2421);
    check("rst_read", {31'd0, ppuRead}, 32'h1);
    reset_n = 1'b1;

    // Address sequence for one tile
    bgPatternTable = 1'b1;
    tile_nt = 8'h5A;
    #1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("addr_ph%0d", k), {18'd0, ppuAddr}, {18'd0, addr_exp[k >> 1]});
      tick();
    end
    check("addr_wrap_ph", {29'd0, dut.ph}, 32'h0);

    // Prefetch A then B; A ends in the high byte
    do_reset();
    fetch_tile(8'h80, 8'h00, 8'h03);
    check("tileA_pat_lo", {16'd0, dut.sh_pat_lo}, 32'h0080);
    check("tileA_at_hi", {16'd0, dut.sh_at_hi}, 32'h00FF);
    fetch_tile(8'h00, 8'hFF, 8'h00);
    check("pre_pat_lo", {16'd0, dut.sh_pat_lo}, 32'h8000);
    check("pre_pat_hi", {16'd0, dut.sh_pat_hi}, 32'h00FF);
    check("pre_at_lo", {16'd0, dut.sh_at_lo}, 32'hFF00);
    check("pre_at_hi", {16'd0, dut.sh_at_hi}, 32'hFF00);
    run_line("fx0", 3'd0, 1'b1, 1'b1, 36'hDCCC_CCCC_2);

    prefetch_ab();
    run_line("fx3", 3'd3, 1'b1, 1'b1, 36'hCCCC_C222_2);

    prefetch_ab();
    run_line("lmask", 3'd0, 1'b1, 1'b0, 36'h0000_0000_2);

    prefetch_ab();
    run_line("bgoff", 3'd0, 1'b0, 1'b1, 36'h0000_0000_0);

    // Dummy fetch: address pinned to NT, shifters untouched
    do_reset();
    fetch_tile(8'h80, 8'h00, 8'h03);
    dummyFetch_EN = 1'b1;
    tile_at = 8'h00;
    tile_lo = 8'h55;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("dummy_addr%0d", k), {18'd0, ppuAddr}, 32'h2421);
      tick();
    end
    check("dummy_pat_lo", {16'd0, dut.sh_pat_lo}, 32'h0080);
    check("dummy_at_lo", {16'd0, dut.sh_at_lo}, 32'h00FF);
    dummyFetch_EN = 1'b0;

    // Freeze mid-tile, then the tile completes normally
    do_reset();
    tile_lo = 8'h80;
    tile_hi = 8'h00;
    tile_at = 8'h03;
    repeat (3) tick();
    clock_EN = 1'b0;
    repeat (5) tick();
    check("frz_ph", {29'd0, dut.ph}, 32'h3);
    check("frz_addr", {18'd0, ppuAddr}, 32'h27C0);
    clock_EN = 1'b1;
    repeat (5) tick();
    check("frz_pat_lo", {16'd0, dut.sh_pat_lo}, 32'h0080);
    check("frz_at_hi", {16'd0, dut.sh_at_hi}, 32'h00FF);

    // Strobe drop mid-tile: back to ph0, no reload
    do_reset();
    tile_lo = 8'hAA;
    repeat (6) tick();
    backgroundFetch_EN = 1'b0;
    tick();
    check("drop_ph", {29'd0, dut.ph}, 32'h0);
    tick();
    check("drop_pat_lo", {16'd0, dut.sh_pat_lo}, 32'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
